// File: rtl/mult_pkg.sv
// Shared definitions for the sequential digit-serial multiplier: FSM states
// and elaboration-time parameter legality checks.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit digit_legal(int digit);
    return (digit == 1) || (digit == 2) || (digit == 4);
  endfunction

  function automatic bit width_legal(int width, int digit);
    return (width >= 2) && (digit > 0) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/mult_digit.sv
// Combinational WIDTH x DIGIT unsigned partial product: AND-array rows summed
// with a small adder chain.
module mult_digit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       d,
  output logic [WIDTH+DIGIT-1:0] pp
);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pp = '0;
    for (int i = 0; i < DIGIT; i++) begin
      pp = pp + ((WIDTH + DIGIT)'(a & {WIDTH{d[i]}}) << i);
    end
  end

endmodule

// File: rtl/seq_array_mult.sv
// Sequential signed/unsigned multiplier: one DIGIT-bit multiplier slice per
// cycle, sign applied to the magnitude product on the final BUSY edge.
module seq_array_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(digit_legal(DIGIT) && width_legal(WIDTH, DIGIT))) begin : g_illegal_params
    $error("seq_array_mult: illegal WIDTH/DIGIT combination");
  end

  state_t             state, state_next;
  logic [WIDTH-1:0]   mag_a, mag_b_sh;
  logic               neg;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]       a_abs, b_abs;
  logic [WIDTH+DIGIT-1:0] pp;

  // Two's-complement magnitude fits WIDTH unsigned bits, including -2^(WIDTH-1).
  assign a_abs = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_abs = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;

  mult_digit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_digit (
    .a  (mag_a),
    .d  (mag_b_sh[DIGIT-1:0]),
    .pp (pp)
  );

  assign acc_next = acc + ((2 * WIDTH)'(pp) << (DIGIT * int'(cnt)));

  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    case (state)
      IDLE:    if (in_valid)     state_next = BUSY;
      BUSY:    if (cnt == LAST)  state_next = DONE;
      DONE:    if (out_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a    <= '0;
      mag_b_sh <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      p        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_a    <= a_abs;
            mag_b_sh <= b_abs;
            neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
          end
        end
        BUSY: begin
          acc      <= acc_next;
          cnt      <= cnt + 1'b1;
          mag_b_sh <= mag_b_sh >> DIGIT;
          if (cnt == LAST) begin
            p <= neg ? (~acc_next + 1'b1) : acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
